// File: rtl/wordle_guess_ctrl.sv
// Guess-entry and scoring controller for the wordle game: collects five letters,
// scores them against the secret word (greens, then yellows), and holds the result until acked.
module wordle_guess_ctrl #(
    parameter int WORD_LEN = 5,
    parameter int CHAR_W   = 8
) (
    input  logic                       Clk,
    input  logic                       reset_n,
    input  logic                       clear,
    input  logic                       letter_valid,
    input  logic [CHAR_W-1:0]          letter_in,
    input  logic                       bksp,
    input  logic                       enter,
    input  logic [WORD_LEN*CHAR_W-1:0] secret,
    input  logic                       result_ack,
    output logic [WORD_LEN*CHAR_W-1:0] guess,
    output logic [2:0]                 len,
    output logic                       busy,
    output logic                       reject,
    output logic                       result_valid,
    output logic [2*WORD_LEN-1:0]      result,
    output logic                       win
);

    typedef enum logic [1:0] {ENTRY, MATCH, YELLOW, REPORT} state_t;

    localparam logic [2:0]            FULL      = 3'(WORD_LEN);
    localparam logic [2:0]            LAST      = 3'(WORD_LEN - 1);
    localparam logic [1:0]            GRAY      = 2'b00;
    localparam logic [1:0]            YEL       = 2'b01;
    localparam logic [1:0]            GREEN     = 2'b10;
    localparam logic [2*WORD_LEN-1:0] ALL_GREEN = {WORD_LEN{GREEN}};
    localparam logic [CHAR_W-1:0]     LO_A      = CHAR_W'(8'h61);
    localparam logic [CHAR_W-1:0]     LO_Z      = CHAR_W'(8'h7A);
    localparam logic [CHAR_W-1:0]     UP_A      = CHAR_W'(8'h41);
    localparam logic [CHAR_W-1:0]     UP_Z      = CHAR_W'(8'h5A);
    localparam logic [CHAR_W-1:0]     CASE_GAP  = CHAR_W'(8'h20);

    state_t              state, next_state;
    logic [CHAR_W-1:0]   slot_q  [WORD_LEN];
    logic [CHAR_W-1:0]   sec_q   [WORD_LEN];
    logic [1:0]          score_q [WORD_LEN];
    logic [2:0]          len_q, idx_q;
    logic [WORD_LEN-1:0] green_q, used_q;
    logic                reject_q;

    logic [CHAR_W-1:0]   letter_up;
    logic                letter_ok, len_full, match_hit, yel_found;
    logic [2:0]          yel_pos;

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        letter_up = letter_in;
        if (letter_in >= LO_A && letter_in <= LO_Z)
            letter_up = letter_in - CASE_GAP;
        letter_ok = (letter_up >= UP_A) && (letter_up <= UP_Z);
        len_full  = (len_q == FULL);
        match_hit = (slot_q[idx_q] == sec_q[idx_q]);
        // Scan downwards so the last hit written is the lowest free matching position.
        yel_found = 1'b0;
        yel_pos   = '0;
        for (int j = WORD_LEN - 1; j >= 0; j--) begin
            if (!used_q[j] && sec_q[j] == slot_q[idx_q]) begin
                yel_found = 1'b1;
                yel_pos   = 3'(j);
            end
        end
    end

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) state <= ENTRY;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (clear) begin
            next_state = ENTRY;
        end else begin
            case (state)
                ENTRY:   if (enter && len_full) next_state = MATCH;
                MATCH:   if (idx_q == LAST)     next_state = YELLOW;
                YELLOW:  if (idx_q == LAST)     next_state = REPORT;
                REPORT:  if (result_ack)        next_state = ENTRY;
                default:                        next_state = ENTRY;
            endcase
        end
    end

    always_comb begin
        busy         = (state != ENTRY);
        result_valid = (state == REPORT);
        reject       = reject_q;
        len          = len_q;
        guess        = '0;
        result       = '0;
        for (int i = 0; i < WORD_LEN; i++) begin
            guess[(WORD_LEN-1-i)*CHAR_W +: CHAR_W] = slot_q[i];
            if (result_valid)
                result[2*(WORD_LEN-1-i) +: 2] = score_q[i];
        end
        win = result_valid && (result == ALL_GREEN);
    end

    // NOTE: the arrays are reset here because they feed outputs that must read 0 after reset.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < WORD_LEN; i++) begin
                slot_q[i]  <= '0;
                sec_q[i]   <= '0;
                score_q[i] <= GRAY;
            end
            len_q    <= '0;
            idx_q    <= '0;
            green_q  <= '0;
            used_q   <= '0;
            reject_q <= 1'b0;
        end else begin
            reject_q <= 1'b0;
            if (clear) begin
                for (int i = 0; i < WORD_LEN; i++) begin
                    slot_q[i]  <= '0;
                    score_q[i] <= GRAY;
                end
                len_q <= '0;
            end else begin
                case (state)
                    ENTRY: begin
                        if (enter) begin
                            if (!len_full) begin
                                reject_q <= 1'b1;
                            end else begin
                                for (int i = 0; i < WORD_LEN; i++) begin
                                    sec_q[i]   <= secret[(WORD_LEN-1-i)*CHAR_W +: CHAR_W];
                                    score_q[i] <= GRAY;
                                end
                                green_q <= '0;
                                used_q  <= '0;
                                idx_q   <= '0;
                            end
                        end else if (bksp) begin
                            if (len_q != '0) begin
                                len_q                 <= len_q - 3'd1;
                                slot_q[len_q - 3'd1]  <= '0;
                            end
                        end else if (letter_valid) begin
                            if (letter_ok && !len_full) begin
                                slot_q[len_q] <= letter_up;
                                len_q         <= len_q + 3'd1;
                            end else begin
                                reject_q <= 1'b1;
                            end
                        end
                    end
                    MATCH: begin
                        if (match_hit) begin
                            green_q[idx_q] <= 1'b1;
                            used_q[idx_q]  <= 1'b1;
                            score_q[idx_q] <= GREEN;
                        end
                        idx_q <= (idx_q == LAST) ? '0 : idx_q + 3'd1;
                    end
                    YELLOW: begin
                        if (!green_q[idx_q] && yel_found) begin
                            used_q[yel_pos] <= 1'b1;
                            score_q[idx_q]  <= YEL;
                        end
                        idx_q <= (idx_q == LAST) ? '0 : idx_q + 3'd1;
                    end
                    REPORT: begin
                        if (result_ack) begin
                            for (int i = 0; i < WORD_LEN; i++) begin
                                slot_q[i]  <= '0;
                                score_q[i] <= GRAY;
                            end
                            len_q <= '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_wordle_guess_ctrl.sv
// Bench for wordle_guess_ctrl: directed scenarios plus randomized guesses scored
// by a plain Wordle reference model.
module tb_wordle_guess_ctrl;

    logic        Clk;
    logic        reset_n;
    logic        clear;
    logic        letter_valid;
    logic [7:0]  letter_in;
    logic        bksp;
    logic        enter;
    logic [39:0] secret;
    logic        result_ack;
    logic [39:0] guess;
    logic [2:0]  len;
    logic        busy;
    logic        reject;
    logic        result_valid;
    logic [9:0]  result;
    logic        win;

    int total = 0;
    int bad   = 0;

    wordle_guess_ctrl #(.WORD_LEN(5), .CHAR_W(8)) dut (
        .Clk(Clk), .reset_n(reset_n), .clear(clear), .letter_valid(letter_valid),
        .letter_in(letter_in), .bksp(bksp), .enter(enter), .secret(secret),
        .result_ack(result_ack), .guess(guess), .len(len), .busy(busy),
        .reject(reject), .result_valid(result_valid), .result(result), .win(win)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Uppercased, zero-padded 40-bit word; position 0 in the top byte.
    function automatic logic [39:0] pack(input string w);
        logic [39:0] p;
        logic [7:0]  c;
        p = '0;
        for (int i = 0; i < 5; i++) begin
            c = (i < w.len()) ? w[i] : 8'h00;
            if (c >= 8'h61 && c <= 8'h7A) c = c - 8'h20;
            p[39-8*i -: 8] = c;
        end
        return p;
    endfunction

    // Standard Wordle scoring: greens first, then left-to-right yellows
    // each consuming the lowest unclaimed matching secret letter.
    function automatic logic [9:0] model_score(input logic [39:0] g, input logic [39:0] s);
        logic [7:0] gc [5];
        logic [7:0] sc [5];
        bit         taken [5];
        bit         grn [5];
        logic [9:0] r;
        r = '0;
        for (int i = 0; i < 5; i++) begin
            gc[i]    = g[39-8*i -: 8];
            sc[i]    = s[39-8*i -: 8];
            taken[i] = 1'b0;
            grn[i]   = 1'b0;
        end
        for (int i = 0; i < 5; i++) begin
            if (gc[i] == sc[i]) begin
                grn[i]         = 1'b1;
                taken[i]       = 1'b1;
                r[9-2*i -: 2]  = 2'b10;
            end
        end
        for (int i = 0; i < 5; i++) begin
            if (!grn[i]) begin
                for (int j = 0; j < 5; j++) begin
                    if (!taken[j] && sc[j] == gc[i]) begin
                        taken[j]      = 1'b1;
                        r[9-2*i -: 2] = 2'b01;
                        break;
                    end
                end
            end
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic key(input logic [7:0] c);
        letter_valid = 1'b1;
        letter_in    = c;
        tick();
        letter_valid = 1'b0;
    endtask

    task automatic type_word(input string w);
        for (int i = 0; i < w.len(); i++) key(w[i]);
    endtask

    task automatic press_enter();
        enter = 1'b1;
        tick();
        enter = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!result_valid && n < 30) begin
            tick();
            n++;
        end
    endtask

    task automatic do_ack();
        result_ack = 1'b1;
        tick();
        result_ack = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #3;
        total++;
        if ({guess, len, busy, reject, result_valid, result, win} !== 58'd0) begin
            bad++;
            $display("FAIL reset_during got=%h exp=0", {guess, len, busy, reject, result_valid, result, win});
        end
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        total++;
        if ({guess, len, busy, reject, result_valid, result, win} !== 58'd0) begin
            bad++;
            $display("FAIL reset_after got=%h exp=0", {guess, len, busy, reject, result_valid, result, win});
        end
    endtask

    task automatic test_short_enter_bksp();
        type_word("robo");
        total++;
        if (len !== 3'd4 || guess !== pack("ROBO")) begin
            bad++;
            $display("FAIL typed_robo got len=%0d guess=%h exp len=4 guess=%h", len, guess, pack("ROBO"));
        end
        press_enter();
        total++;
        if ({reject, busy, len} !== {1'b1, 1'b0, 3'd4}) begin
            bad++;
            $display("FAIL short_enter got reject=%b busy=%b len=%0d exp 1 0 4", reject, busy, len);
        end
        tick();
        total++;
        if (reject !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reject_width got reject=%b busy=%b exp 0 0", reject, busy);
        end
        for (int i = 0; i < 5; i++) begin
            bksp = 1'b1;
            tick();
            bksp = 1'b0;
            total++;
            if (reject !== 1'b0 || len !== 3'((i < 4) ? 3 - i : 0)) begin
                bad++;
                $display("FAIL bksp_%0d got reject=%b len=%0d exp 0 %0d", i, reject, len, (i < 4) ? 3 - i : 0);
            end
        end
        total++;
        if (guess !== 40'd0) begin
            bad++;
            $display("FAIL bksp_empty got guess=%h exp 0", guess);
        end
    endtask

    task automatic test_score_hold_ack();
        int lat;
        secret = pack("ROBOT");
        type_word("BOOST");
        press_enter();
        total++;
        if (busy !== 1'b1 || result_valid !== 1'b0) begin
            bad++;
            $display("FAIL busy_after_enter got busy=%b valid=%b exp 1 0", busy, result_valid);
        end
        wait_valid(lat);
        total++;
        if (lat !== 10) begin
            bad++;
            $display("FAIL latency got=%0d exp=10", lat);
        end
        total++;
        if (result !== 10'h192 || win !== 1'b0) begin
            bad++;
            $display("FAIL robot_boost got result=%h win=%b exp 192 0", result, win);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if ({result_valid, result, guess, len, busy} !== {1'b1, 10'h192, pack("BOOST"), 3'd5, 1'b1}) begin
                bad++;
                $display("FAIL hold_%0d got valid=%b result=%h guess=%h len=%0d", i, result_valid, result, guess, len);
            end
        end
        do_ack();
        total++;
        if ({result_valid, result, guess, len, busy, win} !== 56'd0) begin
            bad++;
            $display("FAIL after_ack got valid=%b result=%h guess=%h len=%0d busy=%b", result_valid, result, guess, len, busy);
        end
    endtask

    task automatic test_fixed_word(input string sec, input string gs, input logic [9:0] exp_r, input logic exp_w);
        int lat;
        secret = pack(sec);
        type_word(gs);
        press_enter();
        wait_valid(lat);
        total++;
        if (lat !== 10 || result !== exp_r || win !== exp_w || guess !== pack(gs)) begin
            bad++;
            $display("FAIL word_%s_%s got lat=%0d result=%h win=%b guess=%h exp 10 %h %b %h",
                     sec, gs, lat, result, win, guess, exp_r, exp_w, pack(gs));
        end
        do_ack();
        total++;
        if (result_valid !== 1'b0 || len !== 3'd0) begin
            bad++;
            $display("FAIL ack_%s got valid=%b len=%0d exp 0 0", sec, result_valid, len);
        end
    endtask

    task automatic test_illegal();
        string odd = "7@[`{";
        type_word("AB");
        for (int i = 0; i < odd.len(); i++) begin
            key(odd[i]);
            total++;
            if ({reject, len} !== {1'b1, 3'd2}) begin
                bad++;
                $display("FAIL bad_char_%0d got reject=%b len=%0d exp 1 2", i, reject, len);
            end
        end
        type_word("CDE");
        key("F");
        total++;
        if ({reject, len, guess} !== {1'b1, 3'd5, pack("ABCDE")}) begin
            bad++;
            $display("FAIL sixth_letter got reject=%b len=%0d guess=%h exp 1 5 %h", reject, len, guess, pack("ABCDE"));
        end
        letter_valid = 1'b1;
        letter_in    = "Z";
        bksp         = 1'b1;
        tick();
        letter_valid = 1'b0;
        bksp         = 1'b0;
        total++;
        if ({reject, len, guess} !== {1'b0, 3'd4, pack("ABCD")}) begin
            bad++;
            $display("FAIL bksp_wins got reject=%b len=%0d guess=%h exp 0 4 %h", reject, len, guess, pack("ABCD"));
        end
        enter = 1'b1;
        bksp  = 1'b1;
        tick();
        enter = 1'b0;
        bksp  = 1'b0;
        total++;
        if ({reject, len, busy} !== {1'b1, 3'd4, 1'b0}) begin
            bad++;
            $display("FAIL enter_wins got reject=%b len=%0d busy=%b exp 1 4 0", reject, len, busy);
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        total++;
        if (len !== 3'd0 || guess !== 40'd0) begin
            bad++;
            $display("FAIL clear_entry got len=%0d guess=%h exp 0 0", len, guess);
        end
    endtask

    task automatic test_clear_mid_match();
        int seen;
        secret = pack("PLANT");
        type_word("PLANE");
        press_enter();
        for (int e = 1; e <= 3; e++) begin
            letter_valid = (e == 1);
            letter_in    = "X";
            bksp         = (e == 2);
            enter        = (e == 3);
            tick();
            letter_valid = 1'b0;
            bksp         = 1'b0;
            enter        = 1'b0;
            total++;
            if ({busy, reject, len} !== {1'b1, 1'b0, 3'd5}) begin
                bad++;
                $display("FAIL busy_ignore_%0d got busy=%b reject=%b len=%0d exp 1 0 5", e, busy, reject, len);
            end
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        total++;
        if ({busy, result_valid, len, guess} !== 45'd0) begin
            bad++;
            $display("FAIL clear_match got busy=%b valid=%b len=%0d guess=%h exp all 0", busy, result_valid, len, guess);
        end
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (result_valid) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL no_result_after_clear got valid_cycles=%0d exp 0", seen);
        end
    endtask

    task automatic test_reset_in_report();
        int lat;
        secret = pack("PLANT");
        type_word("plant");
        press_enter();
        wait_valid(lat);
        total++;
        if (result_valid !== 1'b1 || win !== 1'b1) begin
            bad++;
            $display("FAIL report_win got valid=%b win=%b exp 1 1", result_valid, win);
        end
        reset_n = 1'b0;
        #1;
        total++;
        if ({guess, len, busy, reject, result_valid, result, win} !== 58'd0) begin
            bad++;
            $display("FAIL async_reset got=%h exp=0", {guess, len, busy, reject, result_valid, result, win});
        end
        #2;
        reset_n = 1'b1;
        tick();
        total++;
        if (busy !== 1'b0 || result_valid !== 1'b0) begin
            bad++;
            $display("FAIL after_reset got busy=%b valid=%b exp 0 0", busy, result_valid);
        end
    endtask

    task automatic test_random();
        logic [39:0] s, g;
        logic [9:0]  exp_r;
        logic [7:0]  c;
        int          lat, hold, mode;
        for (int it = 0; it < 40; it++) begin
            s = '0;
            g = '0;
            for (int i = 0; i < 5; i++) s[39-8*i -: 8] = 8'h41 + 8'($urandom_range(0, 3));
            secret = s;
            for (int i = 0; i < 5; i++) begin
                c = 8'h41 + 8'($urandom_range(0, 3));
                g[39-8*i -: 8] = c;
                key(($urandom_range(0, 1) == 1) ? c + 8'h20 : c);
            end
            press_enter();
            secret = {$urandom, 8'($urandom)};
            exp_r  = model_score(g, s);
            total++;
            if (busy !== 1'b1) begin
                bad++;
                $display("FAIL rnd_busy_%0d got=%b exp=1", it, busy);
            end
            wait_valid(lat);
            total++;
            if (lat !== 10 || result !== exp_r || win !== (exp_r == 10'h2AA) || guess !== g) begin
                bad++;
                $display("FAIL rnd_score_%0d got lat=%0d result=%h win=%b guess=%h exp 10 %h %b %h",
                         it, lat, result, win, guess, exp_r, exp_r == 10'h2AA, g);
            end
            hold = $urandom_range(0, 2);
            for (int h = 0; h < hold; h++) tick();
            mode       = $urandom_range(0, 2);
            result_ack = (mode != 2);
            clear      = (mode != 0);
            tick();
            result_ack = 1'b0;
            clear      = 1'b0;
            total++;
            if ({result_valid, busy, len, guess, result, win} !== 56'd0) begin
                bad++;
                $display("FAIL rnd_release_%0d mode=%0d got valid=%b busy=%b len=%0d result=%h",
                         it, mode, result_valid, busy, len, result);
            end
        end
    endtask

    initial begin
        reset_n      = 1'b0;
        clear        = 1'b0;
        letter_valid = 1'b0;
        letter_in    = 8'h00;
        bksp         = 1'b0;
        enter        = 1'b0;
        secret       = '0;
        result_ack   = 1'b0;
        test_reset();
        test_short_enter_bksp();
        test_score_hold_ack();
        test_fixed_word("ABBOT", "BBBBB", 10'h0A0, 1'b0);
        test_fixed_word("CRIMP", "crimp", 10'h2AA, 1'b1);
        test_illegal();
        test_clear_mid_match();
        test_reset_in_report();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
